// File: rtl/s420_match_capture.sv
// s420_match_capture: timestamps qualified Z match events into a small FIFO
// and hands them to the next stage over a valid/ready port.
module s420_match_capture #(
  parameter int TS_W      = 16,
  parameter int DEPTH     = 4,
  parameter int EDGE_ONLY = 1,
  parameter int DROP_W    = 8
) (
  input  logic                       CK,
  input  logic                       RST_N,
  input  logic                       P_0,
  input  logic                       Z,
  output logic                       EV_VALID,
  input  logic                       EV_READY,
  output logic [TS_W-1:0]            EV_TS,
  output logic [$clog2(DEPTH):0]     EV_LEVEL,
  output logic                       OVF,
  output logic [DROP_W-1:0]          DROP_CNT,
  input  logic                       OVF_CLR
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [TS_W-1:0]   ts;
  logic              z_q;
  logic [TS_W-1:0]   mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [LW-1:0]     level;
  logic              ovf;
  logic [DROP_W-1:0] drop_cnt;

  logic ev;
  logic pop;
  logic full;
  logic push_ok;
  logic drop;

  always_comb begin
    ev      = (EDGE_ONLY != 0) ? (Z & ~z_q) : Z;
    pop     = (level != '0) & EV_READY;
    full    = (level == LW'(DEPTH));
    push_ok = ev & (~full | pop);
    drop    = ev & ~push_ok;
  end

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      ts  <= '0;
      z_q <= 1'b0;
    end else begin
      z_q <= Z;
      if (P_0)
        ts <= ts + 1'b1;
    end
  end

  // Storage carries no reset; EV_TS is masked while the FIFO is empty.
  always_ff @(posedge CK) begin
    if (push_ok)
      mem[wr_ptr] <= ts;
  end

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      unique case (1'b1)
        push_ok & ~pop: level <= level + 1'b1;
        pop & ~push_ok: level <= level - 1'b1;
        default:        level <= level;
      endcase
    end
  end

  // A drop in the same cycle as a clear leaves exactly one drop recorded.
  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (OVF_CLR) begin
      ovf      <= drop;
      drop_cnt <= drop ? DROP_W'(1) : '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (drop_cnt != '1)
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

  always_comb begin
    EV_VALID = (level != '0);
    EV_TS    = EV_VALID ? mem[rd_ptr] : '0;
    EV_LEVEL = level;
    OVF      = ovf;
    DROP_CNT = drop_cnt;
  end

endmodule

// File: tb/tb_s420_match_capture.sv
// tb_s420_match_capture: directed checks of the match-capture FIFO,
// edge and level event modes, wrap, drop saturation and async reset.
module tb_s420_match_capture;

  logic CK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CK = ~CK;

  logic p0, z, rdy, clr;
  logic valid, ovf;
  logic [15:0] ts;
  logic [2:0] lvl;
  logic [7:0] drop;

  logic p0_b, z_b, rdy_b, clr_b;
  logic valid_b, ovf_b;
  logic [15:0] ts_b;
  logic [2:0] lvl_b;
  logic [7:0] drop_b;

  int n_cmp = 0;
  int n_fail = 0;

  s420_match_capture #(
    .TS_W(16), .DEPTH(4), .EDGE_ONLY(1), .DROP_W(8)
  ) dut (
    .CK(CK), .RST_N(RST_N), .P_0(p0), .Z(z),
    .EV_VALID(valid), .EV_READY(rdy), .EV_TS(ts),
    .EV_LEVEL(lvl), .OVF(ovf), .DROP_CNT(drop),
    .OVF_CLR(clr)
  );

  s420_match_capture #(
    .TS_W(16), .DEPTH(4), .EDGE_ONLY(0), .DROP_W(8)
  ) dut_lvl (
    .CK(CK), .RST_N(RST_N), .P_0(p0_b), .Z(z_b),
    .EV_VALID(valid_b), .EV_READY(rdy_b), .EV_TS(ts_b),
    .EV_LEVEL(lvl_b), .OVF(ovf_b), .DROP_CNT(drop_b),
    .OVF_CLR(clr_b)
  );

  task automatic tick;
    @(posedge CK);
    #1;
  endtask

  task automatic rst_all;
    p0 = 0; z = 0; rdy = 0; clr = 0;
    p0_b = 0; z_b = 0; rdy_b = 0; clr_b = 0;
    @(negedge CK);
    RST_N = 1'b0;
    @(negedge CK);
    RST_N = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge CK);
    RST_N = 1'b0;
    p0 = 1; z = 1'bx; z_b = 1'bx; p0_b = 1;
    tick;
    tick;
    n_cmp++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_valid got %0b want 0", valid);
    end
    n_cmp++;
    if (ts !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_ts got %h want 0000", ts);
    end
    n_cmp++;
    if (lvl !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_level got %0d want 0", lvl);
    end
    n_cmp++;
    if (ovf !== 1'b0 || drop !== 8'h0) begin
      n_fail++;
      $display("FAIL rst_ovf got %0b/%h want 0/00", ovf, drop);
    end
    n_cmp++;
    if (valid_b !== 1'b0 || lvl_b !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_lvl_dut got %0b/%0d want 0/0", valid_b, lvl_b);
    end
    z = 0; z_b = 0; p0 = 0; p0_b = 0;
    @(negedge CK);
    RST_N = 1'b1;
  endtask

  task automatic test_single_event;
    rst_all;
    p0 = 1;
    repeat (5) tick;
    z = 1;
    tick;
    n_cmp++;
    if (valid !== 1'b1) begin
      n_fail++;
      $display("FAIL t1_valid got %0b want 1", valid);
    end
    n_cmp++;
    if (ts !== 16'h0005) begin
      n_fail++;
      $display("FAIL t1_ts got %h want 0005", ts);
    end
    n_cmp++;
    if (lvl !== 3'd1) begin
      n_fail++;
      $display("FAIL t1_level got %0d want 1", lvl);
    end
    z = 0; rdy = 1;
    tick;
    n_cmp++;
    if (valid !== 1'b0 || ts !== 16'h0) begin
      n_fail++;
      $display("FAIL t1_pop got %0b/%h want 0/0000", valid, ts);
    end
    tick;
    n_cmp++;
    if (lvl !== 3'd0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_empty_pop got %0d/%0b want 0/0", lvl, valid);
    end
    rdy = 0;
  endtask

  task automatic test_edge_vs_level;
    int seen;
    seen = 0;
    rst_all;
    z = 1; rdy = 1;
    p0_b = 1; z_b = 1; rdy_b = 0;
    repeat (10) begin
      tick;
      if (valid === 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 1) begin
      n_fail++;
      $display("FAIL t2_edge_count got %0d want 1", seen);
    end
    n_cmp++;
    if (drop !== 8'h0 || lvl !== 3'd0) begin
      n_fail++;
      $display("FAIL t2_edge_state got %h/%0d want 00/0", drop, lvl);
    end
    n_cmp++;
    if (lvl_b !== 3'd4) begin
      n_fail++;
      $display("FAIL t2_level_fill got %0d want 4", lvl_b);
    end
    n_cmp++;
    if (drop_b !== 8'd6 || ovf_b !== 1'b1) begin
      n_fail++;
      $display("FAIL t2_level_drop got %0d/%0b want 6/1", drop_b, ovf_b);
    end
    n_cmp++;
    if (ts_b !== 16'h0 || valid_b !== 1'b1) begin
      n_fail++;
      $display("FAIL t2_level_head got %h/%0b want 0000/1", ts_b, valid_b);
    end
    z = 0; rdy = 0; z_b = 0;
  endtask

  task automatic test_wrap;
    rst_all;
    p0 = 1;
    repeat (65535) tick;
    z = 1;
    tick;
    p0 = 0; z = 0;
    tick;
    z = 1;
    tick;
    z = 0;
    n_cmp++;
    if (lvl !== 3'd2 || ts !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL t3_first got %0d/%h want 2/ffff", lvl, ts);
    end
    rdy = 1;
    tick;
    n_cmp++;
    if (lvl !== 3'd1 || ts !== 16'h0000) begin
      n_fail++;
      $display("FAIL t3_second got %0d/%h want 1/0000", lvl, ts);
    end
    tick;
    n_cmp++;
    if (lvl !== 3'd0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL t3_drain got %0d/%0b want 0/0", lvl, valid);
    end
    rdy = 0;
  endtask

  task automatic test_full_pop_push;
    logic [15:0] exp;
    rst_all;
    p0 = 1;
    for (int k = 0; k < 8; k++) begin
      z = (k % 2 == 0);
      tick;
    end
    n_cmp++;
    if (lvl !== 3'd4 || ts !== 16'h0) begin
      n_fail++;
      $display("FAIL t4_full got %0d/%h want 4/0000", lvl, ts);
    end
    z = 1; rdy = 1;
    tick;
    n_cmp++;
    if (lvl !== 3'd4 || ts !== 16'h0002) begin
      n_fail++;
      $display("FAIL t4_swap got %0d/%h want 4/0002", lvl, ts);
    end
    n_cmp++;
    if (drop !== 8'h0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_nodrop got %h/%0b want 00/0", drop, ovf);
    end
    z = 0;
    for (int i = 0; i < 4; i++) begin
      exp = 16'(2 + 2 * i);
      n_cmp++;
      if (ts !== exp) begin
        n_fail++;
        $display("FAIL t4_drain%0d got %h want %h", i, ts, exp);
      end
      tick;
    end
    n_cmp++;
    if (lvl !== 3'd0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_empty got %0d/%0b want 0/0", lvl, valid);
    end
    rdy = 0;
  endtask

  task automatic test_drop_saturation;
    rst_all;
    z_b = 1; rdy_b = 0;
    repeat (4 + 254) tick;
    n_cmp++;
    if (drop_b !== 8'hFE) begin
      n_fail++;
      $display("FAIL t5_pre_sat got %h want fe", drop_b);
    end
    tick;
    n_cmp++;
    if (drop_b !== 8'hFF) begin
      n_fail++;
      $display("FAIL t5_at_sat got %h want ff", drop_b);
    end
    repeat (45) tick;
    n_cmp++;
    if (drop_b !== 8'hFF || ovf_b !== 1'b1 || lvl_b !== 3'd4) begin
      n_fail++;
      $display("FAIL t5_sat got %h/%0b/%0d want ff/1/4", drop_b, ovf_b, lvl_b);
    end
    clr_b = 1;
    tick;
    n_cmp++;
    if (ovf_b !== 1'b1 || drop_b !== 8'h01) begin
      n_fail++;
      $display("FAIL t5_clr_drop got %0b/%h want 1/01", ovf_b, drop_b);
    end
    z_b = 0;
    tick;
    n_cmp++;
    if (ovf_b !== 1'b0 || drop_b !== 8'h00) begin
      n_fail++;
      $display("FAIL t5_clr got %0b/%h want 0/00", ovf_b, drop_b);
    end
    clr_b = 0;
  endtask

  task automatic test_async_reset;
    rst_all;
    p0 = 1;
    for (int k = 0; k < 6; k++) begin
      z = (k % 2 == 0);
      tick;
    end
    z = 0;
    n_cmp++;
    if (lvl !== 3'd3 || ts !== 16'h0) begin
      n_fail++;
      $display("FAIL t6_queued got %0d/%h want 3/0000", lvl, ts);
    end
    #1 RST_N = 1'b0;
    #1;
    n_cmp++;
    if (valid !== 1'b0 || lvl !== 3'd0 || ts !== 16'h0) begin
      n_fail++;
      $display("FAIL t6_async got %0b/%0d/%h want 0/0/0000", valid, lvl, ts);
    end
    #1 RST_N = 1'b1;
    z = 1; p0 = 1;
    tick;
    n_cmp++;
    if (valid !== 1'b1 || lvl !== 3'd1 || ts !== 16'h0) begin
      n_fail++;
      $display("FAIL t6_restart got %0b/%0d/%h want 1/1/0000", valid, lvl, ts);
    end
    z = 0;
  endtask

  initial begin
    test_reset;
    test_single_event;
    test_edge_vs_level;
    test_wrap;
    test_full_pop_push;
    test_drop_saturation;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/s420_match_capture.md
Name: s420_match_capture

Overview:
- Downstream consumer of the s420 counter/comparator's Z output.
- Keeps its own 16-bit timestamp counter that advances in lock-step with the counter enable P_0.
- On each qualified Z match event, records the timestamp in a small FIFO and presents it on a valid/ready output port to the next stage (interrupt/logging logic).
- Counts dropped events when the FIFO is full and flags overflow.

Parameters:
TS_W, 16, timestamp counter width; must equal the upstream counter width.
DEPTH, 4, FIFO entries; power of two, 2..16.
EDGE_ONLY, 1, 1 = only a Z rising edge is an event; 0 = every cycle with Z=1 is an event.
DROP_W, 8, width of the saturating dropped-event counter.

Ports:
CK  input  1  clock; all state updates on the rising edge.
RST_N  input  1  asynchronous active-low reset.
P_0  input  1  count enable, shared with the upstream counter; advances TS.
Z  input  1  match output of the upstream comparator; sampled on CK.
EV_VALID  output  1  FIFO not empty.
EV_READY  input  1  consumer accepts the head entry when EV_VALID & EV_READY.
EV_TS  output  TS_W  timestamp at the FIFO head; 0 when empty.
EV_LEVEL  output  clog2(DEPTH)+1  current number of entries.
OVF  output  1  sticky: at least one event was dropped.
DROP_CNT  output  DROP_W  dropped events; saturates at all-ones.
OVF_CLR  input  1  synchronous clear of OVF and DROP_CNT.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - TS=0, z_q=0, FIFO empty (rd/wr pointers 0).
  - EV_VALID=0, EV_TS=0, EV_LEVEL=0, OVF=0, DROP_CNT=0.
  - Reset asserted mid-operation discards all entries immediately. The first edge after release behaves like cycle 0.
- Timestamp counter:
  - TS <= TS+1 on each edge with P_0=1; holds otherwise.
  - Wraps from 2^TS_W-1 to 0.
  - TS uses the same increment rule as the upstream counter, so TS matches its count when both leave reset together.
- Event detection:
  - z_q <= Z every cycle.
  - EDGE_ONLY=1: ev = Z & ~z_q.
  - EDGE_ONLY=0: ev = Z.
- Captured value:
  - The TS value before this edge's increment, i.e. the count the comparator was evaluating when Z was sampled.
- Push/pop:
  - pop = EV_VALID & EV_READY.
  - push_ok = ev & (level<DEPTH | pop). When full, a simultaneous pop frees the slot in the same cycle, so the event is accepted.
  - Level update: push_ok & ~pop: level+1; pop & ~push_ok: level-1; both: unchanged, head advances and tail is written.
  - Pointers wrap modulo DEPTH.
- Output timing:
  - EV_TS/EV_VALID are driven from registered FIFO state.
  - Latency: an event sampled at edge n is visible on EV_VALID after edge n, provided the FIFO was empty.
  - No combinational path from Z or EV_READY to EV_VALID/EV_TS.
  - EV_TS must hold stable while EV_VALID=1 and EV_READY=0.
- Drop:
  - Condition: ev & ~push_ok.
  - Action: OVF <= 1; DROP_CNT <= DROP_CNT+1, holding at 2^DROP_W-1.
  - OVF_CLR=1 clears both. If a drop occurs in the same cycle as OVF_CLR, the result is OVF=1, DROP_CNT=1; the drop wins over the clear.
- Empty pop: EV_READY=1 with EV_VALID=0 has no effect.
- X on Z during reset is ignored; z_q is forced to 0.

Test Plan:
1. Reset, then P_0=1 for 5 cycles; pulse Z=1 for 1 cycle at edge 5 -> EV_VALID=1 after edge 5, EV_TS=0x0005, EV_LEVEL=1. Raise EV_READY -> EV_VALID=0 after the next edge.
2. EDGE_ONLY=1, Z held high for 10 cycles with EV_READY=1 -> exactly 1 entry pushed. With EDGE_ONLY=0 and EV_READY=0 -> 4 entries (DEPTH=4), DROP_CNT=6, OVF=1.
3. Timestamp wrap: preload by running 65535 P_0 cycles, then Z edge at TS=0xFFFF and another at TS=0x0000 -> EV_TS sequence 0xFFFF, 0x0000.
4. FIFO full, EV_READY=1 and new Z edge in the same cycle -> no drop, EV_LEVEL stays 4, head advances, new tail timestamp is correct.
5. 300 drops with DROP_W=8 -> DROP_CNT=0xFF. OVF_CLR together with a drop -> OVF=1, DROP_CNT=1. OVF_CLR alone -> OVF=0, DROP_CNT=0.
6. RST_N pulsed low between edges with 3 entries queued -> outputs go to reset values immediately (before the next CK edge), EV_LEVEL=0, TS restarts at 0.
